// File: rtl/dma_chan_sched.sv
// ============================================================================
// Module   : dma_chan_sched
// Function : Multi-channel DMA descriptor scheduler. Accepts one descriptor
//            per channel, splits each transfer into chunks of at most
//            CHUNK_BYTES and time-slices the chunks of all active channels
//            onto one shared copy engine (round-robin or fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_chan_sched #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int CHUNK_BYTES = 256,
  parameter int ARB_MODE    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_req_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_src_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_dst_i,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  ch_len_i,
  output logic [NUM_CH-1:0]            ch_ack_o,
  output logic [NUM_CH-1:0]            ch_done_o,
  output logic [NUM_CH-1:0]            ch_err_o,
  input  logic                         abort_i,
  output logic                         eng_start_o,
  output logic [$clog2(NUM_CH)-1:0]    eng_ch_o,
  output logic [ADDR_WIDTH-1:0]        eng_src_o,
  output logic [ADDR_WIDTH-1:0]        eng_dst_o,
  output logic [LEN_WIDTH-1:0]         eng_len_o,
  input  logic                         eng_done_i,
  input  logic                         eng_err_i,
  output logic                         busy_o
);

  localparam int CW = $clog2(NUM_CH);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;

  // One extra bit so a chunk size equal to 2^LEN_WIDTH still compares correctly.
  localparam logic [LEN_WIDTH:0] c_chunk = (LEN_WIDTH+1)'(CHUNK_BYTES);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;

  // Per-channel context. r_zero marks a zero-length descriptor that only
  // needs its completion pulse and is never offered to the arbiter.
  logic [NUM_CH-1:0]     r_active;
  logic [NUM_CH-1:0]     r_zero;
  logic [ADDR_WIDTH-1:0] r_src [NUM_CH];
  logic [ADDR_WIDTH-1:0] r_dst [NUM_CH];
  logic [LEN_WIDTH-1:0]  r_rem [NUM_CH];

  logic [NUM_CH-1:0]     r_ack;
  logic [NUM_CH-1:0]     r_done;
  logic [NUM_CH-1:0]     r_err;

  logic [CW-1:0]         r_ptr;
  logic                  r_abort_pend;

  // Chunk currently owned by the engine; held from issue until completion.
  logic [CW-1:0]         r_eng_ch;
  logic [ADDR_WIDTH-1:0] r_eng_src;
  logic [ADDR_WIDTH-1:0] r_eng_dst;
  logic [LEN_WIDTH-1:0]  r_eng_len;

  logic [NUM_CH-1:0]     w_accept;
  logic [NUM_CH-1:0]     w_elig;
  logic [CW-1:0]         w_win;
  logic                  w_win_vld;
  logic [LEN_WIDTH-1:0]  w_win_len;
  int                    w_idx;
  logic                  w_grant;
  logic                  w_wait_done;
  logic                  w_abort_clr;
  logic [ADDR_WIDTH-1:0] w_step;

  assign w_accept    = ch_req_i & ~r_active & {NUM_CH{~r_abort_pend}};
  assign w_elig      = r_active & ~r_zero;
  assign w_grant     = (r_state == c_st_idle) && !r_abort_pend && w_win_vld;
  assign w_wait_done = (r_state == c_st_wait) && eng_done_i;
  assign w_abort_clr = (r_state == c_st_idle) && r_abort_pend;
  assign w_step      = ADDR_WIDTH'(r_eng_len);

  // Arbiter: first eligible channel starting at ptr (round-robin) or at 0 (fixed).
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = (ARB_MODE == 1) ? i : int'(r_ptr) + i;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_win_vld && w_elig[w_idx]) begin
        w_win     = CW'(w_idx);
        w_win_vld = 1'b1;
      end
    end
  end

  // Chunk length for the winner: min(remaining, CHUNK_BYTES).
  always_comb begin
    if ({1'b0, r_rem[w_win]} < c_chunk) w_win_len = r_rem[w_win];
    else                                w_win_len = c_chunk[LEN_WIDTH-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; an abort sweep in IDLE takes precedence over a grant.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_grant) w_state_nxt = c_st_issue;
      c_st_issue: w_state_nxt = c_st_wait;
      c_st_wait:  if (eng_done_i) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // FSM outputs and registered status outputs.
  always_comb begin
    eng_start_o = (r_state == c_st_issue);
    busy_o      = (r_state != c_st_idle) || (|r_active);
    eng_ch_o    = r_eng_ch;
    eng_src_o   = r_eng_src;
    eng_dst_o   = r_eng_dst;
    eng_len_o   = r_eng_len;
    ch_ack_o    = r_ack;
    ch_done_o   = r_done;
    ch_err_o    = r_err;
  end

  // Latch the winning chunk descriptor when leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eng_ch  <= '0;
      r_eng_src <= '0;
      r_eng_dst <= '0;
      r_eng_len <= '0;
    end else if (w_grant) begin
      r_eng_ch  <= w_win;
      r_eng_src <= r_src[w_win];
      r_eng_dst <= r_dst[w_win];
      r_eng_len <= w_win_len;
    end
  end

  // Round-robin pointer moves past the channel whose chunk just finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else if (w_wait_done) begin
      if (r_eng_ch == CW'(NUM_CH - 1)) r_ptr <= '0;
      else                             r_ptr <= r_eng_ch + CW'(1);
    end
  end

  // Abort is remembered until the FSM next sits in IDLE and sweeps the channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_abort_pend <= 1'b0;
    else     r_abort_pend <= (r_abort_pend && !w_abort_clr) || abort_i;
  end

  // Channel contexts: accept, zero-length finish, chunk retire, abort sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= '0;
      r_zero   <= '0;
      r_ack    <= '0;
      r_done   <= '0;
      r_err    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_src[k] <= '0;
        r_dst[k] <= '0;
        r_rem[k] <= '0;
      end
    end else begin
      r_ack  <= w_accept;
      r_done <= '0;
      r_err  <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_accept[k]) begin
          r_active[k] <= 1'b1;
          r_src[k]    <= ch_src_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          r_dst[k]    <= ch_dst_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          r_rem[k]    <= ch_len_i[k*LEN_WIDTH +: LEN_WIDTH];
          r_zero[k]   <= (ch_len_i[k*LEN_WIDTH +: LEN_WIDTH] == '0);
        end
        if (r_zero[k]) begin
          r_active[k] <= 1'b0;
          r_zero[k]   <= 1'b0;
          r_done[k]   <= 1'b1;
        end
        if (w_wait_done && (r_eng_ch == CW'(k))) begin
          r_src[k] <= r_src[k] + w_step;
          r_dst[k] <= r_dst[k] + w_step;
          r_rem[k] <= r_rem[k] - r_eng_len;
          if (eng_err_i || (r_rem[k] == r_eng_len)) begin
            r_active[k] <= 1'b0;
            r_done[k]   <= 1'b1;
            r_err[k]    <= eng_err_i;
          end
        end
        if (w_abort_clr && r_active[k]) begin
          r_active[k] <= 1'b0;
          r_zero[k]   <= 1'b0;
          r_done[k]   <= 1'b1;
          r_err[k]    <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_chan_sched.sv
// ============================================================================
// Module   : tb_dma_chan_sched
// Function : Directed self-checking bench for dma_chan_sched. One instance in
//            round-robin mode, one in fixed-priority mode, each with a simple
//            engine responder that logs issued chunks and completion events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_chan_sched;

  typedef struct {
    int          ch;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
  } iss_t;

  typedef struct {
    int         cyc;
    logic [3:0] d;
    logic [3:0] e;
  } evt_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin instance signals
  logic [3:0]   a_req;
  logic [127:0] a_src, a_dst;
  logic [63:0]  a_len;
  logic [3:0]   a_ack, a_done, a_err;
  logic         a_abort, a_start, a_eng_done, a_eng_err, a_busy;
  logic [1:0]   a_ch;
  logic [31:0]  a_esrc, a_edst;
  logic [15:0]  a_elen;

  // Fixed-priority instance signals
  logic [3:0]   b_req;
  logic [127:0] b_src, b_dst;
  logic [63:0]  b_len;
  logic [3:0]   b_ack, b_done, b_err;
  logic         b_abort, b_start, b_eng_done, b_eng_err, b_busy;
  logic [1:0]   b_ch;
  logic [31:0]  b_esrc, b_edst;
  logic [15:0]  b_elen;

  dma_chan_sched #(.NUM_CH(4), .ADDR_WIDTH(32), .LEN_WIDTH(16), .CHUNK_BYTES(256), .ARB_MODE(0)) u_dut_rr (
    .clk(clk), .rst(rst), .ch_req_i(a_req), .ch_src_i(a_src), .ch_dst_i(a_dst), .ch_len_i(a_len),
    .ch_ack_o(a_ack), .ch_done_o(a_done), .ch_err_o(a_err), .abort_i(a_abort),
    .eng_start_o(a_start), .eng_ch_o(a_ch), .eng_src_o(a_esrc), .eng_dst_o(a_edst), .eng_len_o(a_elen),
    .eng_done_i(a_eng_done), .eng_err_i(a_eng_err), .busy_o(a_busy)
  );

  dma_chan_sched #(.NUM_CH(4), .ADDR_WIDTH(32), .LEN_WIDTH(16), .CHUNK_BYTES(256), .ARB_MODE(1)) u_dut_fp (
    .clk(clk), .rst(rst), .ch_req_i(b_req), .ch_src_i(b_src), .ch_dst_i(b_dst), .ch_len_i(b_len),
    .ch_ack_o(b_ack), .ch_done_o(b_done), .ch_err_o(b_err), .abort_i(b_abort),
    .eng_start_o(b_start), .eng_ch_o(b_ch), .eng_src_o(b_esrc), .eng_dst_o(b_edst), .eng_len_o(b_elen),
    .eng_done_i(b_eng_done), .eng_err_i(b_eng_err), .busy_o(b_busy)
  );

  int total = 0;
  int bad   = 0;

  iss_t a_iss[$], b_iss[$], q_iss[$];
  evt_t a_dn[$], a_ak[$], b_dn[$], q_ev[$];
  int   a_cnt = 0, b_cnt = 0, a_err_idx = -1;
  logic a_err_next = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_iss(input string tag, input int i, input int ch,
                         input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    if (i < q_iss.size()) begin
      chk({tag, " ch"},  64'(q_iss[i].ch), 64'(ch));
      chk({tag, " src"}, 64'(q_iss[i].src), 64'(s));
      chk({tag, " dst"}, 64'(q_iss[i].dst), 64'(d));
      chk({tag, " len"}, 64'(q_iss[i].len), 64'(l));
    end else chk({tag, " missing"}, 64'(q_iss.size()), 64'(i + 1));
  endtask

  task automatic chk_evt(input string tag, input int i, input int ecyc,
                         input logic [3:0] d, input logic [3:0] e);
    if (i < q_ev.size()) begin
      if (ecyc >= 0) chk({tag, " cyc"}, 64'(q_ev[i].cyc), 64'(ecyc));
      chk({tag, " vec"}, 64'(q_ev[i].d), 64'(d));
      chk({tag, " err"}, 64'(q_ev[i].e), 64'(e));
    end else chk({tag, " missing"}, 64'(q_ev.size()), 64'(i + 1));
  endtask

  // Engine model for the round-robin instance: completes each chunk two
  // cycles after issue; the chunk numbered a_err_idx completes with error.
  initial begin
    iss_t t;
    evt_t e;
    a_eng_done = 1'b0;
    a_eng_err  = 1'b0;
    forever begin
      @(negedge clk);
      a_eng_done = 1'b0;
      a_eng_err  = 1'b0;
      if (rst) a_cnt = 0;
      else begin
        if (a_cnt > 0) begin
          a_cnt--;
          if (a_cnt == 0) begin
            a_eng_done = 1'b1;
            a_eng_err  = a_err_next;
          end
        end
        if (a_start) begin
          t.ch = int'(a_ch); t.src = a_esrc; t.dst = a_edst; t.len = a_elen;
          a_err_next = (a_iss.size() == a_err_idx);
          a_iss.push_back(t);
          a_cnt = 2;
        end
        if (|a_done) begin
          e.cyc = cyc; e.d = a_done; e.e = a_err;
          a_dn.push_back(e);
        end
        if (|a_ack) begin
          e.cyc = cyc; e.d = a_ack; e.e = 4'h0;
          a_ak.push_back(e);
        end
      end
    end
  end

  // Engine model for the fixed-priority instance (never errors).
  initial begin
    iss_t t;
    evt_t e;
    b_eng_done = 1'b0;
    b_eng_err  = 1'b0;
    forever begin
      @(negedge clk);
      b_eng_done = 1'b0;
      if (rst) b_cnt = 0;
      else begin
        if (b_cnt > 0) begin
          b_cnt--;
          if (b_cnt == 0) b_eng_done = 1'b1;
        end
        if (b_start) begin
          t.ch = int'(b_ch); t.src = b_esrc; t.dst = b_edst; t.len = b_elen;
          b_iss.push_back(t);
          b_cnt = 2;
        end
        if (|b_done) begin
          e.cyc = cyc; e.d = b_done; e.e = b_err;
          b_dn.push_back(e);
        end
      end
    end
  end

  task automatic clear_logs();
    a_iss.delete(); a_dn.delete(); a_ak.delete();
    b_iss.delete(); b_dn.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req = '0; a_abort = 1'b0; b_req = '0; b_abort = 1'b0;
    a_err_idx = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic set_a(input int k, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    a_src[k*32 +: 32] = s; a_dst[k*32 +: 32] = d; a_len[k*16 +: 16] = l;
  endtask

  task automatic set_b(input int k, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    b_src[k*32 +: 32] = s; b_dst[k*32 +: 32] = d; b_len[k*16 +: 16] = l;
  endtask

  task automatic pulse_a(input logic [3:0] m, output int c);
    c = cyc;
    a_req = m;
    @(negedge clk);
    a_req = '0;
  endtask

  task automatic wait_idle_a(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (a_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " idle"}, 64'(a_busy), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle_b(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (b_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " idle"}, 64'(b_busy), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_iss_a(input string tag, input int num);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (a_iss.size() < num && n < 200);
    chk({tag, " issue seen"}, 64'(a_iss.size() >= num), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog bound expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    a_src = '0; a_dst = '0; a_len = '0;
    b_src = '0; b_dst = '0; b_len = '0;

    // Reset: requests held high must not be acknowledged, outputs all zero.
    rst = 1'b1; a_abort = 1'b0; b_abort = 1'b0;
    a_req = 4'hF; b_req = 4'hF;
    set_a(0, 32'h10, 32'h20, 16'd64);
    repeat (3) @(negedge clk);
    chk("rst ack",   64'(a_ack),   64'(0));
    chk("rst done",  64'(a_done),  64'(0));
    chk("rst err",   64'(a_err),   64'(0));
    chk("rst start", 64'(a_start), 64'(0));
    chk("rst busy",  64'(a_busy),  64'(0));
    chk("rst elen",  64'(a_elen),  64'(0));
    chk("rst esrc",  64'(a_esrc),  64'(0));
    chk("rst b ack", 64'(b_ack),   64'(0));
    chk("rst b busy", 64'(b_busy), 64'(0));

    // S1: 600-byte transfer split into 256/256/88.
    do_reset();
    set_a(0, 32'h1000, 32'h2000, 16'd600);
    pulse_a(4'b0001, c);
    wait_idle_a("s1");
    q_iss = a_iss;
    chk("s1 n_issue", 64'(q_iss.size()), 64'(3));
    chk_iss("s1 i0", 0, 0, 32'h1000, 32'h2000, 16'd256);
    chk_iss("s1 i1", 1, 0, 32'h1100, 32'h2100, 16'd256);
    chk_iss("s1 i2", 2, 0, 32'h1200, 32'h2200, 16'd88);
    q_ev = a_ak;
    chk("s1 n_ack", 64'(q_ev.size()), 64'(1));
    chk_evt("s1 ack", 0, c + 1, 4'b0001, 4'b0000);
    q_ev = a_dn;
    chk("s1 n_done", 64'(q_ev.size()), 64'(1));
    chk_evt("s1 done", 0, -1, 4'b0001, 4'b0000);

    // S2: round-robin interleaving of ch0 and ch2.
    do_reset();
    set_a(0, 32'h0100, 32'h0800, 16'd512);
    set_a(2, 32'h0300, 32'h0A00, 16'd512);
    pulse_a(4'b0101, c);
    wait_idle_a("s2");
    q_iss = a_iss;
    chk("s2 n_issue", 64'(q_iss.size()), 64'(4));
    chk_iss("s2 i0", 0, 0, 32'h0100, 32'h0800, 16'd256);
    chk_iss("s2 i1", 1, 2, 32'h0300, 32'h0A00, 16'd256);
    chk_iss("s2 i2", 2, 0, 32'h0200, 32'h0900, 16'd256);
    chk_iss("s2 i3", 3, 2, 32'h0400, 32'h0B00, 16'd256);
    q_ev = a_ak;
    chk_evt("s2 ack", 0, c + 1, 4'b0101, 4'b0000);
    q_ev = a_dn;
    chk("s2 n_done", 64'(q_ev.size()), 64'(2));
    chk_evt("s2 done0", 0, -1, 4'b0001, 4'b0000);
    chk_evt("s2 done1", 1, -1, 4'b0100, 4'b0000);

    // S3: fixed priority, ch1 runs to completion before ch3.
    do_reset();
    set_b(1, 32'h0010, 32'h0020, 16'd512);
    set_b(3, 32'h0030, 32'h0040, 16'd512);
    b_req = 4'b1010;
    @(negedge clk);
    b_req = '0;
    wait_idle_b("s3");
    q_iss = b_iss;
    chk("s3 n_issue", 64'(q_iss.size()), 64'(4));
    chk_iss("s3 i0", 0, 1, 32'h0010, 32'h0020, 16'd256);
    chk_iss("s3 i1", 1, 1, 32'h0110, 32'h0120, 16'd256);
    chk_iss("s3 i2", 2, 3, 32'h0030, 32'h0040, 16'd256);
    chk_iss("s3 i3", 3, 3, 32'h0130, 32'h0140, 16'd256);
    q_ev = b_dn;
    chk("s3 n_done", 64'(q_ev.size()), 64'(2));
    chk_evt("s3 done0", 0, -1, 4'b0010, 4'b0000);
    chk_evt("s3 done1", 1, -1, 4'b1000, 4'b0000);

    // S4: zero-length descriptor completes without touching the engine.
    do_reset();
    set_a(2, 32'h0055, 32'h0066, 16'd0);
    pulse_a(4'b0100, c);
    wait_idle_a("s4");
    chk("s4 n_issue", 64'(a_iss.size()), 64'(0));
    q_ev = a_ak;
    chk_evt("s4 ack", 0, c + 1, 4'b0100, 4'b0000);
    q_ev = a_dn;
    chk("s4 n_done", 64'(q_ev.size()), 64'(1));
    chk_evt("s4 done", 0, c + 2, 4'b0100, 4'b0000);

    // S5: abort during WAIT: chunk finishes, then both channels fail together.
    do_reset();
    set_a(0, 32'h1000, 32'h5000, 16'd1024);
    set_a(1, 32'h4000, 32'h6000, 16'd1024);
    pulse_a(4'b0011, c);
    wait_iss_a("s5", 1);
    @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    wait_idle_a("s5");
    q_iss = a_iss;
    chk("s5 n_issue", 64'(q_iss.size()), 64'(1));
    chk_iss("s5 i0", 0, 0, 32'h1000, 32'h5000, 16'd256);
    q_ev = a_dn;
    chk("s5 n_done", 64'(q_ev.size()), 64'(1));
    chk_evt("s5 done", 0, -1, 4'b0011, 4'b0011);

    // S6: engine error on ch3's second chunk; ch1 carries on.
    do_reset();
    a_err_idx = 3;
    set_a(1, 32'h0100, 32'h0200, 16'd768);
    set_a(3, 32'h0700, 32'h0900, 16'd768);
    pulse_a(4'b1010, c);
    wait_idle_a("s6");
    q_iss = a_iss;
    chk("s6 n_issue", 64'(q_iss.size()), 64'(5));
    chk_iss("s6 i0", 0, 1, 32'h0100, 32'h0200, 16'd256);
    chk_iss("s6 i1", 1, 3, 32'h0700, 32'h0900, 16'd256);
    chk_iss("s6 i2", 2, 1, 32'h0200, 32'h0300, 16'd256);
    chk_iss("s6 i3", 3, 3, 32'h0800, 32'h0A00, 16'd256);
    chk_iss("s6 i4", 4, 1, 32'h0300, 32'h0400, 16'd256);
    q_ev = a_dn;
    chk("s6 n_done", 64'(q_ev.size()), 64'(2));
    chk_evt("s6 done0", 0, -1, 4'b1000, 4'b1000);
    chk_evt("s6 done1", 1, -1, 4'b0010, 4'b0000);

    // S7: reset in mid-transfer discards the descriptor silently.
    do_reset();
    set_a(0, 32'h1000, 32'h2000, 16'd600);
    pulse_a(4'b0001, c);
    wait_iss_a("s7", 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("s7 n_done", 64'(a_dn.size()), 64'(0));
    chk("s7 n_issue", 64'(a_iss.size()), 64'(1));
    chk("s7 busy", 64'(a_busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_chan_sched.md
DMA_CHAN_SCHED -- requirements
Module: dma_chan_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels, 2..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: source and destination address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16: byte-length width.
REQ-004 SHALL have parameter CHUNK_BYTES, default 256: maximum bytes per engine issue; must be a power of 2.
REQ-005 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port ch_req_i, input, NUM_CH bits: per-channel descriptor valid.
REQ-009 SHALL have port ch_src_i, input, NUM_CH*ADDR_WIDTH bits: per-channel source address, channel k in slice k.
REQ-010 SHALL have port ch_dst_i, input, NUM_CH*ADDR_WIDTH bits: per-channel destination address.
REQ-011 SHALL have port ch_len_i, input, NUM_CH*LEN_WIDTH bits: per-channel byte length.
REQ-012 SHALL have port ch_ack_o, output, NUM_CH bits: one-cycle pulse when a descriptor is accepted.
REQ-013 SHALL have port ch_done_o, output, NUM_CH bits: one-cycle completion pulse.
REQ-014 SHALL have port ch_err_o, output, NUM_CH bits: qualifies ch_done_o; 1 means error or abort.
REQ-015 SHALL have port abort_i, input, 1 bit: abort all channels.
REQ-016 SHALL have port eng_start_o, output, 1 bit: one-cycle chunk issue to the shared engine.
REQ-017 SHALL have port eng_ch_o, output, $clog2(NUM_CH) bits: channel of the issued chunk.
REQ-018 SHALL have ports eng_src_o and eng_dst_o, output, ADDR_WIDTH bits each, and eng_len_o, output, LEN_WIDTH bits: the chunk descriptor, held stable from eng_start_o until eng_done_i.
REQ-019 SHALL have ports eng_done_i and eng_err_i, input, 1 bit each: chunk complete, with eng_err_i qualifying the completion.
REQ-020 SHALL have port busy_o, output, 1 bit: any channel active or state not IDLE.

Function
REQ-021 SHALL keep a per-channel context: active, src, dst, remaining.
REQ-022 SHALL accept ch_req_i[k] only when active[k]=0 and no abort is pending; in the next cycle it SHALL set active[k], load the context and pulse ch_ack_o[k].
REQ-023 SHALL allow acceptance on any channel in any state, with several channels accepted in the same cycle.
REQ-024 SHALL, for a descriptor with length 0, pulse ch_ack_o[k] and pulse ch_done_o[k] with ch_err_o[k]=0 one cycle later, never issuing it to the engine.
REQ-025 SHALL implement the state machine IDLE -> ISSUE -> WAIT -> IDLE.
REQ-026 SHALL, in IDLE with any active channel, select a winner per ARB_MODE and enter ISSUE next cycle.
REQ-027 SHALL, in round-robin mode, search from ptr to ptr+NUM_CH-1 modulo NUM_CH; after each chunk ptr SHALL become (winner+1) mod NUM_CH.
REQ-028 SHALL assert eng_start_o in ISSUE for exactly one cycle with eng_len_o = min(remaining, CHUNK_BYTES), then enter WAIT.
REQ-029 SHALL, on eng_done_i in WAIT, add the chunk length to src and dst (wrapping at 2^ADDR_WIDTH), subtract it from remaining, and return to IDLE next cycle.
REQ-030 SHALL, when remaining reaches 0, clear active and pulse ch_done_o with ch_err_o=0; on eng_err_i it SHALL clear active and pulse ch_done_o with ch_err_o=1 regardless of remaining.
REQ-031 SHALL re-arbitrate between chunks, so that channels with long transfers are time-sliced.
REQ-032 SHALL ignore eng_done_i outside WAIT.
REQ-033 SHALL, on abort_i, set abort_pend; in WAIT it SHALL continue waiting for eng_done_i.
REQ-034 SHALL, in IDLE with abort_pend set, clear every active channel, pulse ch_done_o with ch_err_o=1 for each of them in the same cycle, clear abort_pend, and issue nothing.
REQ-035 SHALL let a channel completing in cycle t accept a new request no earlier than t+1.

Reset
REQ-036 SHALL, while rst=1, clear all contexts, ptr=0, state=IDLE, abort_pend=0, and drive all outputs to 0.
REQ-037 SHALL treat reset mid-transfer as a discard with no done pulse.

Verification
REQ-038 SHALL cover: ch0 with src=0x1000, dst=0x2000, len=600 and CHUNK_BYTES=256 -> chunks (0x1000,0x2000,256), (0x1100,0x2100,256), (0x1200,0x2200,88), then ch_done_o[0] with ch_err_o=0.
REQ-039 SHALL cover: ch0 and ch2 each with len=512 in round-robin mode -> issue order 0,2,0,2, each channel with one done pulse.
REQ-040 SHALL cover: ch1 and ch3 requesting in the same cycle with ARB_MODE=1 -> ch1 finishes all chunks before ch3 starts.
REQ-041 SHALL cover: a request with len=0 on ch2 -> ack, then done with err=0 on the next cycle, and eng_start_o never asserted.
REQ-042 SHALL cover: abort_i during WAIT with ch0 and ch1 active -> no new issue after eng_done_i, and both done pulses with err=1 in the same cycle.
REQ-043 SHALL cover: eng_err_i on the second chunk of ch3 -> ch_done_o[3] with ch_err_o[3]=1, after which the other channels continue.
